// File: rtl/fp_op_sequencer.sv
// Issue/writeback sequencer for the FP ALU: one operation in flight, fixed-latency wait,
// then a one-cycle register-file write or a condition-flag update.
module fp_op_sequencer #(
    parameter int LAT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_ctl,
    input  logic        req_mov,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [4:0]  req_fd,
    input  logic [4:0]  req_rd,
    input  logic [31:0] req_gpr,
    output logic [2:0]  alu_ctl,
    output logic [31:0] alu_din1,
    output logic [31:0] alu_din2,
    input  logic [31:0] alu_res,
    input  logic        alu_cc,
    output logic        wr_en,
    output logic [4:0]  wr_addr,
    output logic [31:0] wr_data,
    output logic        cc_flag,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [2:0]  alu_ctl_q, alu_ctl_d;
    logic [31:0] alu_din1_q, alu_din1_d;
    logic [31:0] alu_din2_q, alu_din2_d;
    logic [4:0]  fd_q, fd_d;
    logic        cmp_q, cmp_d;
    logic        wr_en_q, wr_en_d;
    logic [4:0]  wr_addr_q, wr_addr_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic        cc_pend_q, cc_pend_d;
    logic        cc_flag_q, cc_flag_d;
    logic        done_q, done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            alu_ctl_q  <= '0;
            alu_din1_q <= '0;
            alu_din2_q <= '0;
            fd_q       <= '0;
            cmp_q      <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            cc_pend_q  <= 1'b0;
            cc_flag_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            alu_ctl_q  <= alu_ctl_d;
            alu_din1_q <= alu_din1_d;
            alu_din2_q <= alu_din2_d;
            fd_q       <= fd_d;
            cmp_q      <= cmp_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            cc_pend_q  <= cc_pend_d;
            cc_flag_q  <= cc_flag_d;
            done_q     <= done_d;
        end
    end

    // wr_en and done are registered on entry to WB, so they are high for exactly the WB cycle
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        alu_ctl_d  = alu_ctl_q;
        alu_din1_d = alu_din1_q;
        alu_din2_d = alu_din2_q;
        fd_d       = fd_q;
        cmp_d      = cmp_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        cc_pend_d  = cc_pend_q;
        cc_flag_d  = cc_flag_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    alu_ctl_d  = req_ctl;
                    alu_din1_d = req_a;
                    alu_din2_d = req_b;
                    fd_d       = req_fd;
                    cmp_d      = (req_ctl >= 3'd2) && (req_ctl <= 3'd6);
                    if (req_ctl == 3'd7) begin
                        wr_addr_d = req_rd;
                        wr_data_d = req_gpr;
                        wr_en_d   = 1'b1;
                        done_d    = 1'b1;
                        state_d   = WB;
                    end else if (req_ctl == 3'd0 && req_mov) begin
                        wr_addr_d = req_fd;
                        wr_data_d = req_a;
                        wr_en_d   = 1'b1;
                        done_d    = 1'b1;
                        state_d   = WB;
                    end else begin
                        cnt_d   = 4'(LAT - 1);
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                if (cnt_q == 4'd0) begin
                    if (cmp_q) begin
                        cc_pend_d = alu_cc;
                    end else begin
                        wr_data_d = alu_res;
                        wr_addr_d = fd_q;
                        wr_en_d   = 1'b1;
                    end
                    done_d  = 1'b1;
                    state_d = WB;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            WB: begin
                if (cmp_q) begin
                    cc_flag_d = cc_pend_q;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_ready = (state_q == IDLE) && rst_n;
    assign busy      = (state_q != IDLE);
    assign alu_ctl   = alu_ctl_q;
    assign alu_din1  = alu_din1_q;
    assign alu_din2  = alu_din2_q;
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign cc_flag   = cc_flag_q;
    assign done      = done_q;

endmodule

// File: tb/tb_fp_op_sequencer.sv
// Scoreboard bench for fp_op_sequencer: requests push expected completions, a monitor
// pops them on every done pulse and tracks the condition flag.
module tb_fp_op_sequencer;

    localparam int LAT = 3;

    typedef struct {
        bit          wr;
        logic [4:0]  addr;
        logic [31:0] data;
        bit          cmp;
        bit          cc;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic [2:0]  req_ctl = '0;
    logic        req_mov = 1'b0;
    logic [31:0] req_a = '0, req_b = '0, req_gpr = '0;
    logic [4:0]  req_fd = '0, req_rd = '0;

    logic        req_ready, wr_en, cc_flag, busy, done, alu_cc;
    logic [2:0]  alu_ctl;
    logic [31:0] alu_din1, alu_din2, alu_res, wr_data;
    logic [4:0]  wr_addr;

    logic        valid_1 = 1'b0, valid_15 = 1'b0;
    logic        req_ready_1, wr_en_1, cc_flag_1, busy_1, done_1, alu_cc_1;
    logic [2:0]  alu_ctl_1;
    logic [31:0] alu_din1_1, alu_din2_1, alu_res_1, wr_data_1;
    logic [4:0]  wr_addr_1;
    logic        req_ready_15, wr_en_15, cc_flag_15, busy_15, done_15, alu_cc_15;
    logic [2:0]  alu_ctl_15;
    logic [31:0] alu_din1_15, alu_din2_15, alu_res_15, wr_data_15;
    logic [4:0]  wr_addr_15;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   mcc = 1'b0;
    exp_t sbq[$];

    logic [32:0] p3 [0:1];
    logic [32:0] p15 [0:13];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in ALU: integer add/sub, signed compares, plus the one FP sum used in the directed test
    function automatic logic [32:0] aluf(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic        cc;
        r = (c == 3'd1) ? a - b : a + b;
        if (c == 3'd0 && a == 32'h3FC00000 && b == 32'h40100000) r = 32'h40700000;
        case (c)
            3'd2: cc = (a == b);
            3'd3: cc = ($signed(a) <  $signed(b));
            3'd4: cc = ($signed(a) <= $signed(b));
            3'd5: cc = ($signed(a) >= $signed(b));
            3'd6: cc = ($signed(a) >  $signed(b));
            default: cc = 1'b0;
        endcase
        return {cc, r};
    endfunction

    // Expected completion of one request accepted at cycle count acc
    function automatic exp_t model(input logic [2:0] c, input logic m, input logic [31:0] a,
                                   input logic [31:0] b, input logic [4:0] fd, input logic [4:0] rd,
                                   input logic [31:0] gpr, input int acc);
        exp_t        e;
        logic [32:0] f;
        f     = aluf(c, a, b);
        e.cmp = (c >= 3'd2) && (c <= 3'd6);
        e.wr  = !e.cmp;
        e.cc  = f[32];
        if (c == 3'd7) begin
            e.addr = rd; e.data = gpr; e.due = acc;
        end else if (c == 3'd0 && m) begin
            e.addr = fd; e.data = a; e.due = acc;
        end else begin
            e.addr = fd; e.data = f[31:0]; e.due = acc + LAT;
        end
        return e;
    endfunction

    always @(posedge clk) begin
        p3[0] <= aluf(alu_ctl, alu_din1, alu_din2);
        p3[1] <= p3[0];
        p15[0] <= aluf(alu_ctl_15, alu_din1_15, alu_din2_15);
        for (int i = 1; i < 14; i++) p15[i] <= p15[i-1];
    end

    assign {alu_cc, alu_res}       = p3[1];
    assign {alu_cc_15, alu_res_15} = p15[13];
    assign {alu_cc_1, alu_res_1}   = aluf(alu_ctl_1, alu_din1_1, alu_din2_1);

    fp_op_sequencer #(.LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_ctl(req_ctl), .req_mov(req_mov), .req_a(req_a), .req_b(req_b),
        .req_fd(req_fd), .req_rd(req_rd), .req_gpr(req_gpr),
        .alu_ctl(alu_ctl), .alu_din1(alu_din1), .alu_din2(alu_din2),
        .alu_res(alu_res), .alu_cc(alu_cc), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .cc_flag(cc_flag), .busy(busy), .done(done)
    );

    fp_op_sequencer #(.LAT(1)) dut_lat1 (
        .clk(clk), .rst_n(rst_n), .req_valid(valid_1), .req_ready(req_ready_1),
        .req_ctl(req_ctl), .req_mov(req_mov), .req_a(req_a), .req_b(req_b),
        .req_fd(req_fd), .req_rd(req_rd), .req_gpr(req_gpr),
        .alu_ctl(alu_ctl_1), .alu_din1(alu_din1_1), .alu_din2(alu_din2_1),
        .alu_res(alu_res_1), .alu_cc(alu_cc_1), .wr_en(wr_en_1), .wr_addr(wr_addr_1),
        .wr_data(wr_data_1), .cc_flag(cc_flag_1), .busy(busy_1), .done(done_1)
    );

    fp_op_sequencer #(.LAT(15)) dut_lat15 (
        .clk(clk), .rst_n(rst_n), .req_valid(valid_15), .req_ready(req_ready_15),
        .req_ctl(req_ctl), .req_mov(req_mov), .req_a(req_a), .req_b(req_b),
        .req_fd(req_fd), .req_rd(req_rd), .req_gpr(req_gpr),
        .alu_ctl(alu_ctl_15), .alu_din1(alu_din1_15), .alu_din2(alu_din2_15),
        .alu_res(alu_res_15), .alu_cc(alu_cc_15), .wr_en(wr_en_15), .wr_addr(wr_addr_15),
        .wr_data(wr_data_15), .cc_flag(cc_flag_15), .busy(busy_15), .done(done_15)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every falling edge, check reset state, the flag, and any completion against the queue
    always @(negedge clk) begin
        if (!rst_n) begin
            checkOutput("rst_ctrl", {24'd0, wr_en, done, busy, req_ready, cc_flag, alu_ctl}, 32'd0);
            checkOutput("rst_wr_addr", {27'd0, wr_addr}, 32'd0);
            checkOutput("rst_wr_data", wr_data, 32'd0);
            checkOutput("rst_din", alu_din1 | alu_din2, 32'd0);
            sbq.delete();
            mcc = 1'b0;
        end else begin
            checkOutput("busy_vs_ready", {31'd0, busy}, {31'd0, !req_ready});
            checkOutput("cc_flag", {31'd0, cc_flag}, {31'd0, mcc});
            if (wr_en && !done) checkOutput("wr_en_without_done", 32'd1, 32'd0);
            if (done) begin
                if (sbq.size() == 0) begin
                    checkOutput("unexpected_done", {31'd0, wr_en}, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    checkOutput("done_cycle", 32'(cyc), 32'(e.due));
                    checkOutput("wr_en", {31'd0, wr_en}, {31'd0, e.wr});
                    if (e.wr) begin
                        checkOutput("wr_addr", {27'd0, wr_addr}, {27'd0, e.addr});
                        checkOutput("wr_data", wr_data, e.data);
                    end
                    if (e.cmp) mcc = e.cc;
                end
            end
            if (sbq.size() > 0 && cyc > sbq[0].due) begin
                checkOutput("missing_done", 32'(cyc), 32'(sbq[0].due));
                void'(sbq.pop_front());
            end
        end
    end

    // Issue one request; hold keeps req_valid high afterwards for back-to-back issue
    task automatic applyStimulus(input logic [2:0] c, input logic m, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] fd, input logic [4:0] rd,
                                 input logic [31:0] gpr, input bit hold, output int acc);
        int n = 0;
        req_ctl = c; req_mov = m; req_a = a; req_b = b;
        req_fd = fd; req_rd = rd; req_gpr = gpr;
        req_valid = 1'b1;
        while (!req_ready && n < 200) begin
            if (!hold) req_valid = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            n++;
        end
        req_valid = 1'b1;
        if (!req_ready) begin
            checkOutput("accept_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
            acc = -1;
            return;
        end
        sbq.push_back(model(c, m, a, b, fd, rd, gpr, cyc + 1));
        @(posedge clk); #1;
        acc = cyc;
        if (!hold) begin
            req_valid = 1'b0;
            req_a = $urandom; req_b = $urandom; req_ctl = 3'($urandom);
        end
    endtask

    task automatic sideLatency(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] fd);
        int          acc, c1, c15;
        logic [31:0] d1, d15, expd;
        req_ctl = c; req_mov = 1'b0; req_a = a; req_b = b; req_fd = fd;
        valid_1 = 1'b1; valid_15 = 1'b1;
        @(posedge clk); #1;
        acc = cyc;
        valid_1 = 1'b0; valid_15 = 1'b0;
        expd = aluf(c, a, b);
        c1 = -1; c15 = -1; d1 = '0; d15 = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (wr_en_1)  begin c1  = cyc; d1  = wr_data_1;  end
            if (wr_en_15) begin c15 = cyc; d15 = wr_data_15; end
        end
        checkOutput("lat1_cycle", 32'(c1), 32'(acc + 1));
        checkOutput("lat1_data", d1, expd);
        checkOutput("lat15_cycle", 32'(c15), 32'(acc + 15));
        checkOutput("lat15_data", d15, expd);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int a0, a1, a2, acc, n;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        applyStimulus(3'd0, 1'b0, 32'h3FC00000, 32'h40100000, 5'd5, 5'd0, 32'd0, 1'b0, acc);
        applyStimulus(3'd3, 1'b0, 32'h3F800000, 32'h40000000, 5'd0, 5'd0, 32'd0, 1'b0, acc);
        applyStimulus(3'd1, 1'b0, 32'h40400000, 32'h3F800000, 5'd7, 5'd0, 32'd0, 1'b0, acc);
        applyStimulus(3'd2, 1'b0, 32'h3F800000, 32'h40000000, 5'd0, 5'd0, 32'd0, 1'b0, acc);
        applyStimulus(3'd7, 1'b0, 32'd0, 32'd0, 5'd0, 5'd12, 32'hDEADBEEF, 1'b0, acc);
        applyStimulus(3'd0, 1'b1, 32'h41200000, 32'd0, 5'd3, 5'd0, 32'd0, 1'b0, acc);

        applyStimulus(3'd0, 1'b0, 32'h3F800000, 32'h3F800000, 5'd1, 5'd0, 32'd0, 1'b1, a0);
        applyStimulus(3'd0, 1'b0, 32'h40000000, 32'h3F800000, 5'd2, 5'd0, 32'd0, 1'b1, a1);
        applyStimulus(3'd0, 1'b0, 32'h40400000, 32'h3F800000, 5'd4, 5'd0, 32'd0, 1'b1, a2);
        req_valid = 1'b0;
        checkOutput("b2b_gap1", 32'(a1 - a0), 32'(LAT + 2));
        checkOutput("b2b_gap2", 32'(a2 - a1), 32'(LAT + 2));

        applyStimulus(3'd3, 1'b0, 32'h3F800000, 32'h40000000, 5'd0, 5'd0, 32'd0, 1'b0, acc);
        applyStimulus(3'd1, 1'b0, 32'h40400000, 32'h3F800000, 5'd9, 5'd0, 32'd0, 1'b0, acc);
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        applyStimulus(3'd0, 1'b1, 32'h12345678, 32'd0, 5'd30, 5'd0, 32'd0, 1'b0, acc);

        for (int i = 0; i < 150; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
            applyStimulus(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), ra, rb,
                          5'($urandom), 5'($urandom), $urandom, 1'($urandom_range(0, 1)), acc);
        end
        req_valid = 1'b0;

        n = 0;
        while (sbq.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (sbq.size() != 0) checkOutput("drain_timeout", 32'(sbq.size()), 32'd0);
        repeat (2) @(posedge clk); #1;

        sideLatency(3'd0, 32'h3FC00000, 32'h40100000, 5'd5);
        for (int i = 0; i < 3; i++)
            sideLatency(3'($urandom_range(0, 1)), $urandom, $urandom, 5'($urandom));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
